pio_write_arbiter: RTL and testbench

//  Shares one 8-bit output PIO register (Avalon-MM slave, offset 0 = data) between NUM_REQ requesters.

---
 rtl/pio_arb_pkg.sv | 16 +
 rtl/pio_write_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/pio_write_arbiter.sv | 124 ++++++++++++
 tb/tb_pio_write_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_arb_pkg.sv
// rtl/pio_arb_pkg.sv - shared types and constants for the PIO write arbiter
package pio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Avalon word offset of the PIO data register
    localparam logic [1:0] PIO_DATA_OFS = 2'd0;

    // Largest requester count the round-robin arbiter is intended for
    localparam int MAX_REQ = 8;

endpackage

// File: rtl/pio_write_arbiter_if.sv
// rtl/pio_write_arbiter_if.sv - Avalon-MM write-only master bus towards the PIO s1 port
//
// Signals:
//   m_address      word address
//   m_chipselect   chipselect
//   m_write_n      write strobe, active low
//   m_writedata    write data, 32 bits
//   m_waitrequest  slave stall
// Modports: master (arbiter side), slave (PIO side).
interface pio_write_arbiter_if;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_waitrequest
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_waitrequest
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
//
// Ports:
//   req          in   NUM_REQ  request vector
//   last_grant   in   IDX_W    index granted last; search begins at last_grant+1
//   en           in   1        when low no grant is produced
//   grant        out  NUM_REQ  one-hot grant
//   grant_idx    out  IDX_W    index of the granted requester
//   grant_valid  out  1        a grant was produced
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        cand        = '0;
        if (en) begin
            // Walk NUM_REQ candidates starting one past the last grant, wrapping
            // without a modulo so non-power-of-two counts stay cheap.
            for (int i = 1; i <= NUM_REQ; i++) begin
                sum = {1'b0, last_grant} + (IDX_W+1)'(i);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                cand = sum[IDX_W-1:0];
                if (!grant_valid && req[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// rtl/pio_write_arbiter.sv - merges masked bit updates from NUM_REQ agents into one PIO register
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req            in   NUM_REQ         level request, held until ack
//   req_data       in   NUM_REQ*DATA_W  new bit values, slice i = [i*DATA_W +: DATA_W]
//   req_mask       in   NUM_REQ*DATA_W  bits owned by requester i
//   ack            out  NUM_REQ         one-cycle commit pulse
//   busy           out  1               FSM not idle
//   shadow         out  DATA_W          last value written to the PIO
//   avm            master modport       Avalon-MM write bus to the PIO
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int                NUM_REQ  = 4,
    parameter int                DATA_W   = 8,
    parameter logic [1:0]        PIO_ADDR = PIO_DATA_OFS,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_mask,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [DATA_W-1:0]         shadow,
    pio_write_arbiter_if.master       avm
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [IDX_W-1:0]    last_grant;
    logic [DATA_W-1:0]   merged_q;
    logic [DATA_W-1:0]   merged_nxt;
    logic [DATA_W-1:0]   sel_data;
    logic [DATA_W-1:0]   sel_mask;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req),
        .last_grant  (last_grant),
        .en          (state == ST_IDLE),
        .grant       (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_data   = req_data[grant_idx*DATA_W +: DATA_W];
        sel_mask   = req_mask[grant_idx*DATA_W +: DATA_W];
        merged_nxt = (shadow & ~sel_mask) | (sel_data & sel_mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (grant_valid) state_nxt = ST_WRITE;
            ST_WRITE: if (!avm.m_waitrequest) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant latch, shadow and registered Avalon outputs. last_grant resets to
    // the top index so that requester 0 is the first one searched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q          <= '0;
            grant_idx_q      <= '0;
            last_grant       <= IDX_W'(NUM_REQ - 1);
            merged_q         <= INIT_VAL;
            shadow           <= INIT_VAL;
            avm.m_address    <= '0;
            avm.m_chipselect <= 1'b0;
            avm.m_write_n    <= 1'b1;
            avm.m_writedata  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_q          <= grant_oh;
                        grant_idx_q      <= grant_idx;
                        merged_q         <= merged_nxt;
                        avm.m_address    <= PIO_ADDR;
                        avm.m_chipselect <= 1'b1;
                        avm.m_write_n    <= 1'b0;
                        avm.m_writedata  <= 32'(merged_nxt);
                    end
                end
                ST_WRITE: begin
                    if (!avm.m_waitrequest) begin
                        shadow           <= merged_q;
                        last_grant       <= grant_idx_q;
                        avm.m_address    <= '0;
                        avm.m_chipselect <= 1'b0;
                        avm.m_write_n    <= 1'b1;
                        avm.m_writedata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state != ST_IDLE);
        ack  = (state == ST_DONE) ? grant_q : '0;
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb/tb_pio_write_arbiter.sv - self-checking bench for pio_write_arbiter
module tb_pio_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*DW-1:0] req_mask = '0;
    logic [N-1:0]    ack;
    logic            busy;
    logic [DW-1:0]   shadow;
    logic            wr = 1'b0;

    pio_write_arbiter_if bus();
    assign bus.m_waitrequest = wr;

    pio_write_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .req_mask (req_mask),
        .ack      (ack),
        .busy     (busy),
        .shadow   (shadow),
        .avm      (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: bus phase (0 idle, 1 write, 2 ack), shadow, last grant
    int            m_phase = 0;
    logic [DW-1:0] m_shadow = '0;
    logic [DW-1:0] m_val = '0;
    int            m_idx = 0;
    int            m_last = N - 1;
    int            log_idx[$];
    int            log_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    // Called at each falling edge: req/wr still hold what the last rising edge sampled.
    task automatic monitor();
        logic [DW-1:0] d, m;
        cyc++;
        if (!reset_n) begin
            chk("rst_cs", bus.m_chipselect, 0);
            chk("rst_wn", bus.m_write_n, 1);
            chk("rst_ack", ack, 0);
            chk("rst_shadow", shadow, 0);
            chk("rst_busy", busy, 0);
            m_phase = 0; m_shadow = '0; m_last = N - 1;
            return;
        end
        case (m_phase)
            0: if (|req) begin
                m_idx = pick(req, m_last);
                d = req_data[m_idx*DW +: DW];
                m = req_mask[m_idx*DW +: DW];
                m_val = (m_shadow & ~m) | (d & m);
                m_phase = 1;
            end
            1: if (!wr) begin
                m_shadow = m_val;
                m_last = m_idx;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        chk("cs", bus.m_chipselect, (m_phase == 1) ? 1 : 0);
        chk("write_n", bus.m_write_n, (m_phase == 1) ? 0 : 1);
        chk("addr", bus.m_address, 0);
        chk("wdata", bus.m_writedata, (m_phase == 1) ? {24'h0, m_val} : 32'h0);
        chk("ack", ack, (m_phase == 2) ? (32'h1 << m_idx) : 32'h0);
        chk("shadow", shadow, m_shadow);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                log_idx.push_back(i);
                log_cyc.push_back(cyc);
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_ack(input int idx, input int limit, input string tag);
        int n = 0;
        while (1) begin
            tick();
            if (ack[idx]) break;
            n++;
            if (n >= limit) begin
                chk(tag, ack, 32'h1 << idx);
                break;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [7:0] m);
        req_data[i*DW +: DW] = d;
        req_mask[i*DW +: DW] = m;
        req[i] = 1'b1;
    endtask

    initial begin
        int c0;
        // 1: reset values and quiet bus
        tick(3);
        reset_n = 1'b1;
        tick(20);

        // 2: single masked update, latency, post-grant data change ignored
        set_req(0, 8'hA5, 8'h0F);
        c0 = cyc;
        tick();
        chk("t2_wdata", bus.m_writedata, 32'h05);
        req_data[7:0] = 8'hFF;
        wait_ack(0, 10, "t2_ack_timeout");
        chk("t2_latency", cyc - c0, 2);
        tick();
        chk("t2_shadow", shadow, 8'h05);

        // 3: four simultaneous requests from reset, strict rotation
        do_reset();
        log_idx.delete(); log_cyc.delete();
        set_req(0, 8'hA7, 8'h03);
        set_req(1, 8'h34, 8'h0C);
        set_req(2, 8'hE1, 8'h30);
        set_req(3, 8'h4F, 8'hC0);
        for (int k = 0; k < 30 && log_idx.size() < 4; k++) tick();
        chk("t3_count", log_idx.size(), 4);
        for (int k = 0; k < log_idx.size() && k < 4; k++) begin
            chk("t3_order", log_idx[k], k);
            if (k > 0) chk("t3_spacing", log_cyc[k] - log_cyc[k-1], 3);
        end
        tick();
        chk("t3_shadow", shadow, 8'h67);

        // 4: wait states hold the bus stable; ack one cycle after release
        wr = 1'b1;
        set_req(1, 8'h3C, 8'hFF);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall_data", bus.m_writedata, 32'h3C);
            tick();
        end
        chk("t4_stall_cs", bus.m_chipselect, 1);
        wr = 1'b0;
        c0 = cyc;
        wait_ack(1, 10, "t4_ack_timeout");
        chk("t4_ack_delay", cyc - c0, 1);
        tick();

        // 5: zero-mask keep-alive, then overlapping masks
        set_req(2, 8'hFF, 8'h00);
        tick();
        chk("t5_keepalive", bus.m_writedata, 32'h3C);
        wait_ack(2, 10, "t5_ack2_timeout");
        tick();
        log_idx.delete(); log_cyc.delete();
        set_req(1, 8'hF0, 8'hF0);
        set_req(3, 8'h00, 8'h3C);
        for (int k = 0; k < 20 && log_idx.size() < 2; k++) tick();
        chk("t5_count", log_idx.size(), 2);
        if (log_idx.size() == 2) begin
            chk("t5_first", log_idx[0], 3);
            chk("t5_second", log_idx[1], 1);
        end
        tick();
        chk("t5_shadow", shadow, 8'hF0);

        // 6: reset in the middle of a write
        set_req(0, 8'h81, 8'hFF);
        tick();
        chk("t6_in_write", bus.m_chipselect, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_cs", bus.m_chipselect, 0);
        chk("t6_async_ack", ack, 0);
        chk("t6_async_shadow", shadow, 0);
        tick(3);
        reset_n = 1'b1;
        wait_ack(0, 10, "t6_ack_timeout");
        tick();
        chk("t6_shadow", shadow, 8'h81);

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_data[i*DW +: DW] = 8'($urandom);
                        req_mask[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                        req[i] = 1'b1;
                    end
                end else begin
                    if ($urandom_range(0, 15) == 0) req_data[i*DW +: DW] = 8'($urandom);
                    if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
                end
            end
            wr = ($urandom_range(0, 3) == 0);
        end
        wr = 1'b0;
        req = '0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
